// File: rtl/cla_pg_pipe_stage_if.sv
// Handshake bundle between the operand source, the P/G stage and the carry-logic stage.
// WIDTH and CNT_WIDTH must match the parameters of the attached cla_pg_pipe_stage.
interface cla_pg_pipe_stage_if #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   carry_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       p;
  logic [WIDTH-1:0]       g;
  logic [WIDTH/4-1:0]     grp_p;
  logic [WIDTH/4-1:0]     grp_g;
  logic                   out_cin;
  logic [CNT_WIDTH-1:0]   txn_count;

  modport master (
    output in_valid, a, b, carry_in, out_ready,
    input  in_ready, out_valid, p, g, grp_p, grp_g, out_cin, txn_count
  );

  modport slave (
    input  in_valid, a, b, carry_in, out_ready,
    output in_ready, out_valid, p, g, grp_p, grp_g, out_cin, txn_count
  );
endinterface

// File: rtl/cla_pg_pipe_stage.sv
// Registered propagate/generate front end of the CLA datapath with a one-entry
// skid buffer so the input keeps full rate while the carry logic stalls.
module cla_pg_pipe_stage #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input logic             clk,
  input logic             rst,
  cla_pg_pipe_stage_if.slave io
);
  localparam int NG = WIDTH / 4;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [NG-1:0]    gp;
    logic [NG-1:0]    gg;
    logic             cin;
  } res_t;

  function automatic res_t pg_calc(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic cin);
    res_t       r;
    logic [3:0] pk;
    logic [3:0] gk;
    r.p   = a ^ b;
    r.g   = a & b;
    r.cin = cin;
    r.gp  = '0;
    r.gg  = '0;
    for (int k = 0; k < NG; k++) begin
      pk       = r.p[4*k +: 4];
      gk       = r.g[4*k +: 4];
      r.gp[k]  = &pk;
      r.gg[k]  = gk[3] | (pk[3] & gk[2]) | (pk[3] & pk[2] & gk[1]) |
                 (pk[3] & pk[2] & pk[1] & gk[0]);
    end
    return r;
  endfunction

  state_t               state_q, state_d;
  res_t                 m_q, s_q;
  logic                 in_ready_q;
  logic [CNT_WIDTH-1:0] cnt_q;

  res_t pg_in;
  logic in_xfer, out_xfer;
  logic ld_m_in, ld_m_s, ld_s;

  assign pg_in    = pg_calc(io.a, io.b, io.carry_in);
  assign in_xfer  = io.in_valid & in_ready_q;
  assign out_xfer = (state_q != EMPTY) & io.out_ready;

  always_comb begin
    state_d = state_q;
    ld_m_in = 1'b0;
    ld_m_s  = 1'b0;
    ld_s    = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          ld_m_in = 1'b1;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          ld_m_in = 1'b1;
        end else if (in_xfer) begin
          ld_s    = 1'b1;
          state_d = FULL;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only the drain path can fire
        if (out_xfer) begin
          ld_m_s  = 1'b1;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Stage boundary: main/skid registers and handshake state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b0;
      m_q        <= '0;
      s_q        <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
      if (ld_m_in)     m_q <= pg_in;
      else if (ld_m_s) m_q <= s_q;
      if (ld_s)        s_q <= pg_in;
      if (in_xfer)     cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = (state_q != EMPTY);
  assign io.p         = m_q.p;
  assign io.g         = m_q.g;
  assign io.grp_p     = m_q.gp;
  assign io.grp_g     = m_q.gg;
  assign io.out_cin   = m_q.cin;
  assign io.txn_count = cnt_q;
endmodule
